// File: rtl/int_to_fp_conv.sv
// Multi-cycle signed 32-bit integer to FPU operand converter (sign, 6-bit exponent, 25-bit mantissa).
// Optional macro ROUND_NEAREST_EN selects round-to-nearest-even in PACK; otherwise the mantissa is truncated.
module int_to_fp_conv #(
  parameter int EXP_BIAS = 31
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] int_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] fp_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  status_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ABS  = 3'd1,
    NORM = 3'd2,
    PACK = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [5:0] EXP_TOP = 6'(EXP_BIAS + 31);

  state_t      state_q, state_d;
  logic [31:0] int_q, int_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [5:0]  exp_q, exp_d;
  logic [31:0] fp_q, fp_d;
  logic [3:0]  status_q, status_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;

  logic [31:0] abs_s;
  logic [24:0] mant_s;
  logic [5:0]  exp_pack_s;
  logic        inexact_s;
`ifdef ROUND_NEAREST_EN
  logic        round_up_s;
  logic [25:0] mant_sum_s;
`endif

  // Magnitude of the latched operand; -2^31 wraps to 0x80000000 which is the correct unsigned value.
  always_comb begin
    abs_s = int_q;
    if (int_q[31]) begin
      abs_s = ~int_q + 32'd1;
    end else begin
      abs_s = int_q;
    end
  end

  // Mantissa extraction from the normalised magnitude, with optional nearest-even rounding.
  always_comb begin
    inexact_s  = |mag_q[5:0];
    mant_s     = mag_q[30:6];
    exp_pack_s = exp_q;
`ifdef ROUND_NEAREST_EN
    round_up_s = mag_q[5] & ((|mag_q[4:0]) | mag_q[6]);
    mant_sum_s = {1'b0, mag_q[30:6]} + {25'd0, round_up_s};
    if (mant_sum_s[25]) begin
      mant_s     = 25'd0;
      exp_pack_s = exp_q + 6'd1;
    end else begin
      mant_s     = mant_sum_s[24:0];
      exp_pack_s = exp_q;
    end
`endif
  end

  // Next-state and datapath updates for the conversion sequence.
  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    fp_d     = fp_q;
    status_d = status_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          int_d   = int_in;
          state_d = ABS;
        end else begin
          state_d = IDLE;
        end
      end
      ABS: begin
        sign_d = int_q[31];
        mag_d  = abs_s;
        exp_d  = EXP_TOP;
        // Already-normalised magnitudes skip NORM so lz zeros cost exactly lz cycles.
        if ((abs_s == 32'd0) || abs_s[31]) begin
          state_d = PACK;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        mag_d = {mag_q[30:0], 1'b0};
        exp_d = exp_q - 6'd1;
        if (mag_q[30]) begin
          state_d = PACK;
        end else begin
          state_d = NORM;
        end
      end
      PACK: begin
        if (mag_q == 32'd0) begin
          fp_d     = 32'd0;
          status_d = 4'b0001;
        end else begin
          fp_d     = {sign_q, exp_pack_s, mant_s};
          status_d = {1'b0, sign_q, inexact_s, 1'b0};
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset taking priority over any handshake.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      int_q       <= 32'd0;
      sign_q      <= 1'b0;
      mag_q       <= 32'd0;
      exp_q       <= 6'd0;
      fp_q        <= 32'd0;
      status_q    <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      sign_q      <= sign_d;
      mag_q       <= mag_d;
      exp_q       <= exp_d;
      fp_q        <= fp_d;
      status_q    <= status_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign fp_out     = fp_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_int_to_fp_conv.sv
// Directed self-checking bench for int_to_fp_conv: values, status, latency, backpressure and reset.
module tb_int_to_fp_conv;

  logic        clock;
  logic        reset;
  logic [31:0] int_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_out;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  status_out;

  int n_checks = 0;
  int n_fails  = 0;

  int_to_fp_conv #(.EXP_BIAS(31)) dut (
    .clock      (clock),
    .reset      (reset),
    .int_in     (int_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fp_out     (fp_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .status_out (status_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Accept one operand, measure latency, check the result and complete the handshake.
  task automatic convert(input string tag, input logic [31:0] v, input logic [31:0] exp_fp,
                         input logic [3:0] exp_st, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      step();
      guard++;
    end
    int_in   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    int_in   = 32'h5A5A_A5A5;
    lat = 0;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check_val({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_val({tag, "_fp"}, fp_out, exp_fp);
    check_val({tag, "_st"}, {28'd0, status_out}, {28'd0, exp_st});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val({tag, "_ovdrop"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset     = 1'b1;
    int_in    = 32'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_fp", fp_out, 32'd0);
    check_val("rst_status", {28'd0, status_out}, 32'd0);
    reset = 1'b0;
    step();

    convert("one", 32'd1, 32'h3E00_0000, 4'b0000, 33);
    convert("two", 32'd2, 32'h4000_0000, 4'b0000, 32);
    convert("neg1", 32'hFFFF_FFFF, 32'hBE00_0000, 4'b0100, 33);
    convert("zero", 32'd0, 32'h0000_0000, 4'b0001, 2);
`ifdef ROUND_NEAREST_EN
    convert("max", 32'h7FFF_FFFF, 32'h7C00_0000, 4'b0010, 3);
`else
    convert("max", 32'h7FFF_FFFF, 32'h7BFF_FFFF, 4'b0010, 3);
`endif
    convert("min", 32'h8000_0000, 32'hFC00_0000, 4'b0100, 2);
    convert("neg5", 32'hFFFF_FFFB, 32'hC280_0000, 4'b0100, 31);
    convert("k1000", 32'd1000, 32'h51E8_0000, 4'b0000, 24);

    // Backpressure: result held for 10 cycles, a stray in_valid is ignored.
    int_in   = 32'd2;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) step();
    check_val("bp_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      int_in   = 32'd7;
      in_valid = (i == 3);
      out_ready = 1'b0;
      step();
      check_val("bp_fp", fp_out, 32'h4000_0000);
      check_val("bp_st", {28'd0, status_out}, 32'd0);
      check_val("bp_rdy", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_val("bp_release", {31'd0, out_valid}, 32'd0);
    check_val("bp_idle", {31'd0, in_ready}, 32'd1);
    step();
    check_val("bp_no_second", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of normalisation discards the conversion.
    int_in   = 32'd1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
    check_val("mid_rst_fp", fp_out, 32'd0);
    for (int i = 0; i < 40; i++) step();
    check_val("mid_rst_quiet", {31'd0, out_valid}, 32'd0);

    // Reset wins over a simultaneous accept.
    int_in   = 32'd5;
    in_valid = 1'b1;
    reset    = 1'b1;
    step();
    reset    = 1'b0;
    in_valid = 1'b0;
    check_val("rst_prio_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_val("rst_prio_idle", {31'd0, in_ready}, 32'd1);

    convert("after_rst", 32'd2, 32'h4000_0000, 4'b0000, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
